// File: rtl/sgmii_regs_pkg.sv
// ---------------------------------------------------------------------------
// sgmii_regs_pkg
// Shared constants for the multi-channel SGMII / 1000BASE-X PCS register bank:
// register indices, reset defaults, the transmit-state CONFIG encoding and the
// bit positions of the control, interrupt and mode registers.
// Optional feature macro used by the bank: SGMII_REG_IRQ_EN.
// ---------------------------------------------------------------------------
package sgmii_regs_pkg;

  // Register indices (i_Addr[6:2])
  localparam logic [4:0] cRegControl   = 5'h00;
  localparam logic [4:0] cRegStatus    = 5'h01;
  localparam logic [4:0] cRegLcAdv     = 5'h04;
  localparam logic [4:0] cRegLpAdv     = 5'h05;
  localparam logic [4:0] cRegTimerLo   = 5'h08;
  localparam logic [4:0] cRegTimerHi   = 5'h09;
  localparam logic [4:0] cRegScratch   = 5'h0A;
  localparam logic [4:0] cRegIrqStatus = 5'h10;
  localparam logic [4:0] cRegIrqMask   = 5'h11;
  localparam logic [4:0] cRegMode      = 5'h1F;

  // Reset defaults; the control mask keeps only implemented control bits
  localparam logic [15:0] cControlDefault = 16'h1140;
  localparam logic [15:0] cControlMask    = 16'hFB40;
  localparam logic [15:0] cLcAdvDefault   = 16'h01A0;
  localparam logic [15:0] cScratchDefault = 16'h2000;

  // Transmit state machine encoding seen on i_XmitState
  localparam logic [2:0] cXmitIDLE   = 3'd0;
  localparam logic [2:0] cXmitCONFIG = 3'd1;
  localparam logic [2:0] cXmitDATA   = 3'd2;

  // Control register bit positions
  localparam int cCtlReset     = 15;
  localparam int cCtlLoopback  = 14;
  localparam int cCtlSpeedLsb  = 13;
  localparam int cCtlANEnable  = 12;
  localparam int cCtlPowerDown = 11;
  localparam int cCtlANRestart = 9;
  localparam int cCtlDuplex    = 8;
  localparam int cCtlSpeedMsb  = 6;

  // Interrupt status / mask bit positions
  localparam int cIrqLinkDown = 0;
  localparam int cIrqANDone   = 1;
  localparam int cIrqLpChange = 2;

  // Mode register bit positions
  localparam int cModeSgmii = 0;
  localparam int cModePhy   = 1;
  localparam int cModeLocal = 2;

endpackage

// File: rtl/sgmii_reg_channel.sv
// ---------------------------------------------------------------------------
// sgmii_reg_channel
// One PCS channel's management registers: control (self-clearing reset,
// AN restart cleared by the CONFIG transmit state), latched-low link status,
// advertised ability formation, link timer, scratch, mode and, when
// SGMII_REG_IRQ_EN is defined, edge-detected interrupt status and mask.
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_WrEn, i_RdEn      write / read strobe already decoded for this channel
//   i_RegIdx, i_WrData  register index and 16-bit write data
//   o_RdData            combinational read value of i_RegIdx
//   i_*                 per-channel PCS status inputs
//   o_*                 per-channel control / derived outputs
//   o_IrqReq            OR of masked interrupt status (0 without the feature)
// ---------------------------------------------------------------------------
module sgmii_reg_channel
  import sgmii_regs_pkg::*;
#(
  parameter logic [20:0] LINK_TIMER_DEFAULT = 21'h30D40
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_WrEn,
  input  logic        i_RdEn,
  input  logic [4:0]  i_RegIdx,
  input  logic [15:0] i_WrData,
  output logic [15:0] o_RdData,
  input  logic [2:0]  i_XmitState,
  input  logic [15:0] i_TxConfigReg,
  input  logic [15:0] i_LpAdvAbility,
  input  logic        i_ANComplete,
  input  logic        i_SyncStatus,
  input  logic        i_PhyLink,
  input  logic        i_PhyDuplex,
  input  logic [1:0]  i_PhySpeed,
  output logic        o_MIIRst_L,
  output logic        o_ANEnable,
  output logic        o_ANRestart,
  output logic        o_Loopback,
  output logic        o_GXBPowerDown,
  output logic        o_SGMIIDuplex,
  output logic [1:0]  o_SGMIISpeed,
  output logic [15:0] o_LcAdvAbility,
  output logic [20:0] o_LinkTimer,
  output logic        o_IrqReq
);

  logic [15:0] ctl, lcAdv, scratch;
  logic [20:0] linkTimer;
  logic [2:0]  mode, irqStatus, irqMask;
  logic        linkLL;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ctl       <= cControlDefault;
      lcAdv     <= cLcAdvDefault;
      linkTimer <= LINK_TIMER_DEFAULT;
      scratch   <= cScratchDefault;
      mode      <= '0;
      linkLL    <= 1'b0;
    end else begin
      if (i_WrEn && i_RegIdx == cRegControl) begin
        ctl <= i_WrData & cControlMask;
      end else begin
        ctl[cCtlReset] <= 1'b0;
        if (i_XmitState == cXmitCONFIG) ctl[cCtlANRestart] <= 1'b0;
      end
      if (i_WrEn && i_RegIdx == cRegLcAdv)   lcAdv            <= i_WrData;
      if (i_WrEn && i_RegIdx == cRegTimerLo) linkTimer[15:0]  <= i_WrData;
      if (i_WrEn && i_RegIdx == cRegTimerHi) linkTimer[20:16] <= i_WrData[4:0];
      if (i_WrEn && i_RegIdx == cRegScratch) scratch          <= i_WrData;
      if (i_WrEn && i_RegIdx == cRegMode)    mode             <= i_WrData[2:0];
      // A sync drop overrides a coincident status read
      if (!i_SyncStatus)                           linkLL <= 1'b0;
      else if (i_RdEn && i_RegIdx == cRegStatus)  linkLL <= 1'b1;
    end
  end

`ifdef SGMII_REG_IRQ_EN
  logic        syncPrev, anPrev;
  logic [15:0] lpPrev;
  logic [2:0]  irqEvent;

  always_comb begin
    irqEvent               = '0;
    irqEvent[cIrqLinkDown] = syncPrev & ~i_SyncStatus;
    irqEvent[cIrqANDone]   = ~anPrev & i_ANComplete;
    irqEvent[cIrqLpChange] = (lpPrev != i_LpAdvAbility);
  end

  // History always follows the inputs, including during reset, so no event
  // is seen on the first cycle after reset is released.
  always_ff @(posedge i_Clk) begin
    syncPrev <= i_SyncStatus;
    anPrev   <= i_ANComplete;
    lpPrev   <= i_LpAdvAbility;
    if (i_Rst) begin
      irqStatus <= '0;
      irqMask   <= '0;
    end else begin
      // New events are OR-ed after the clear so they win over write-1-to-clear
      if (i_WrEn && i_RegIdx == cRegIrqStatus)
        irqStatus <= (irqStatus & ~i_WrData[2:0]) | irqEvent;
      else
        irqStatus <= irqStatus | irqEvent;
      if (i_WrEn && i_RegIdx == cRegIrqMask) irqMask <= i_WrData[2:0];
    end
  end

  assign o_IrqReq = |(irqStatus & irqMask);
`else
  assign irqStatus = '0;
  assign irqMask   = '0;
  assign o_IrqReq  = 1'b0;
`endif

  // Advertised ability depends on SGMII / PHY-side mode
  always_comb begin
    if (!mode[cModeSgmii])
      o_LcAdvAbility = {1'b0, i_TxConfigReg[15], lcAdv[13:12], 3'b000,
                        lcAdv[8:7], 2'b01, 5'b00000};
    else if (mode[cModePhy])
      o_LcAdvAbility = {i_PhyLink, i_TxConfigReg[15], 1'b0,
                        i_PhyDuplex | lcAdv[12], i_PhySpeed | lcAdv[11:10], 10'h1};
    else
      o_LcAdvAbility = {1'b0, i_TxConfigReg[15], 1'b0, 3'b000, 10'h1};
  end

  always_comb begin
    if (!mode[cModeSgmii]) begin
      o_SGMIISpeed  = 2'b10;
      o_SGMIIDuplex = 1'b1;
    end else if (mode[cModeLocal]) begin
      o_SGMIISpeed  = {ctl[cCtlSpeedMsb] | i_PhySpeed[1], ctl[cCtlSpeedLsb] | i_PhySpeed[0]};
      o_SGMIIDuplex = ctl[cCtlDuplex] | i_PhyDuplex;
    end else begin
      o_SGMIISpeed  = i_LpAdvAbility[11:10];
      o_SGMIIDuplex = i_LpAdvAbility[12];
    end
  end

  // Control bit 15 is self-clearing, so it always reads back as 0
  always_comb begin
    o_RdData = '0;
    case (i_RegIdx)
      cRegControl:   o_RdData = {1'b0, ctl[14:0]};
      cRegStatus:    o_RdData = {9'h0, i_ANComplete, 2'b01, linkLL, i_SyncStatus, 2'b00};
      cRegLcAdv:     o_RdData = o_LcAdvAbility;
      cRegLpAdv:     o_RdData = i_LpAdvAbility;
      cRegTimerLo:   o_RdData = linkTimer[15:0];
      cRegTimerHi:   o_RdData = {11'h0, linkTimer[20:16]};
      cRegScratch:   o_RdData = scratch;
      cRegIrqStatus: o_RdData = {13'h0, irqStatus};
      cRegIrqMask:   o_RdData = {13'h0, irqMask};
      cRegMode:      o_RdData = {13'h0, mode};
      default:       o_RdData = '0;
    endcase
  end

  assign o_MIIRst_L     = ~ctl[cCtlReset];
  assign o_ANEnable     = ctl[cCtlANEnable];
  assign o_ANRestart    = ctl[cCtlANRestart];
  assign o_Loopback     = ctl[cCtlLoopback];
  assign o_GXBPowerDown = ctl[cCtlPowerDown];
  assign o_LinkTimer    = linkTimer;

  // Backing bits that no mode uses in the advertised word
  logic unusedChBits;
  assign unusedChBits = ^{lcAdv[15:14], lcAdv[9], lcAdv[6:0], i_TxConfigReg[14:0]};

endmodule

// File: rtl/sgmii_reg_bank.sv
// ---------------------------------------------------------------------------
// sgmii_reg_bank
// NUM_CH-channel SGMII / 1000BASE-X PCS management register bank behind one
// pipelined Wishbone slave. Every strobe is accepted (o_Stall = 0) and acked
// one cycle later; read data is registered and held until the next read.
// Address: register = i_Addr[6:2], channel = i_Addr[ADDR_W-1:7]; channels at
// or above NUM_CH ignore writes, read 0 and are still acked.
// Optional feature: SGMII_REG_IRQ_EN builds interrupt status/mask and o_Irq.
// Ports:
//   i_Clk, i_Rst                     clock, synchronous active-high reset
//   i_Cyc, i_Stb, i_WEn, i_Addr,
//   i_WrData, o_RdData, o_Ack,
//   o_Stall                          Wishbone slave
//   i_XmitState .. i_PhySpeed        packed per-channel PCS status
//   o_MIIRst_L .. o_LinkTimer        packed per-channel control / derived
//   o_Irq                            registered OR of masked interrupt status
// ---------------------------------------------------------------------------
module sgmii_reg_bank
  import sgmii_regs_pkg::*;
#(
  parameter int          NUM_CH             = 4,
  parameter int          ADDR_W             = 10,
  parameter logic [20:0] LINK_TIMER_DEFAULT = 21'h30D40
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Cyc,
  input  logic                   i_Stb,
  input  logic                   i_WEn,
  input  logic [ADDR_W-1:0]      i_Addr,
  input  logic [31:0]            i_WrData,
  output logic [31:0]            o_RdData,
  output logic                   o_Ack,
  output logic                   o_Stall,
  input  logic [3*NUM_CH-1:0]    i_XmitState,
  input  logic [16*NUM_CH-1:0]   i_TxConfigReg,
  input  logic [16*NUM_CH-1:0]   i_LpAdvAbility,
  input  logic [NUM_CH-1:0]      i_ANComplete,
  input  logic [NUM_CH-1:0]      i_SyncStatus,
  input  logic [NUM_CH-1:0]      i_PhyLink,
  input  logic [NUM_CH-1:0]      i_PhyDuplex,
  input  logic [2*NUM_CH-1:0]    i_PhySpeed,
  output logic [NUM_CH-1:0]      o_MIIRst_L,
  output logic [NUM_CH-1:0]      o_ANEnable,
  output logic [NUM_CH-1:0]      o_ANRestart,
  output logic [NUM_CH-1:0]      o_Loopback,
  output logic [NUM_CH-1:0]      o_GXBPowerDown,
  output logic [NUM_CH-1:0]      o_SGMIIDuplex,
  output logic [2*NUM_CH-1:0]    o_SGMIISpeed,
  output logic [16*NUM_CH-1:0]   o_LcAdvAbility,
  output logic [21*NUM_CH-1:0]   o_LinkTimer,
  output logic                   o_Irq
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CI_W = ADDR_W - 7;

  logic            acc, wrAcc, rdAcc, chValid;
  logic [CI_W-1:0] chIdx;
  logic [CH_W-1:0] chSel;
  logic [4:0]      regIdx;
  logic [15:0]     chRdData [NUM_CH];
  logic [NUM_CH-1:0] chIrq;
  logic [15:0]     selRd;

  assign acc    = i_Cyc & i_Stb;
  assign wrAcc  = acc & i_WEn;
  assign rdAcc  = acc & ~i_WEn;
  assign regIdx = i_Addr[6:2];
  // Full upper address is range-checked so aliases above NUM_CH are rejected
  assign chIdx   = i_Addr[ADDR_W-1:7];
  assign chSel   = chIdx[CH_W-1:0];
  assign chValid = (32'(chIdx) < 32'(NUM_CH));
  assign o_Stall = 1'b0;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    sgmii_reg_channel #(.LINK_TIMER_DEFAULT(LINK_TIMER_DEFAULT)) uCh (
      .i_Clk          (i_Clk),
      .i_Rst          (i_Rst),
      .i_WrEn         (wrAcc && chValid && (chSel == CH_W'(g))),
      .i_RdEn         (rdAcc && chValid && (chSel == CH_W'(g))),
      .i_RegIdx       (regIdx),
      .i_WrData       (i_WrData[15:0]),
      .o_RdData       (chRdData[g]),
      .i_XmitState    (i_XmitState[3*g +: 3]),
      .i_TxConfigReg  (i_TxConfigReg[16*g +: 16]),
      .i_LpAdvAbility (i_LpAdvAbility[16*g +: 16]),
      .i_ANComplete   (i_ANComplete[g]),
      .i_SyncStatus   (i_SyncStatus[g]),
      .i_PhyLink      (i_PhyLink[g]),
      .i_PhyDuplex    (i_PhyDuplex[g]),
      .i_PhySpeed     (i_PhySpeed[2*g +: 2]),
      .o_MIIRst_L     (o_MIIRst_L[g]),
      .o_ANEnable     (o_ANEnable[g]),
      .o_ANRestart    (o_ANRestart[g]),
      .o_Loopback     (o_Loopback[g]),
      .o_GXBPowerDown (o_GXBPowerDown[g]),
      .o_SGMIIDuplex  (o_SGMIIDuplex[g]),
      .o_SGMIISpeed   (o_SGMIISpeed[2*g +: 2]),
      .o_LcAdvAbility (o_LcAdvAbility[16*g +: 16]),
      .o_LinkTimer    (o_LinkTimer[21*g +: 21]),
      .o_IrqReq       (chIrq[g])
    );
  end

  assign selRd = chValid ? chRdData[chSel] : 16'h0;

  // Bus response stage: ack and read data registered one cycle after accept
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Ack    <= 1'b0;
      o_RdData <= '0;
    end else begin
      o_Ack <= acc;
      if (rdAcc) o_RdData <= {16'h0, selRd};
    end
  end

`ifdef SGMII_REG_IRQ_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) o_Irq <= 1'b0;
    else       o_Irq <= |chIrq;
  end
  logic unusedTop;
  assign unusedTop = ^{i_WrData[31:16], i_Addr[1:0]};
`else
  assign o_Irq = 1'b0;
  logic unusedTop;
  assign unusedTop = ^{i_WrData[31:16], i_Addr[1:0], chIrq};
`endif

endmodule

// File: tb/tb_sgmii_reg_bank.sv
module tb_sgmii_reg_bank;

`ifdef SGMII_REG_IRQ_EN
  localparam bit cIrq = 1'b1;
`else
  localparam bit cIrq = 1'b0;
`endif

  logic        i_Clk = 0, i_Rst = 1;
  logic        i_Cyc = 0, i_Stb = 0, i_WEn = 0;
  logic [9:0]  i_Addr = '0;
  logic [31:0] i_WrData = '0;
  logic [31:0] o_RdData;
  logic        o_Ack, o_Stall, o_Irq;
  logic [11:0] i_XmitState = '0;
  logic [63:0] i_TxConfigReg = '0, i_LpAdvAbility = '0;
  logic [3:0]  i_ANComplete = '0, i_SyncStatus = 4'hF, i_PhyLink = '0, i_PhyDuplex = '0;
  logic [7:0]  i_PhySpeed = '0;
  logic [3:0]  o_MIIRst_L, o_ANEnable, o_ANRestart, o_Loopback, o_GXBPowerDown, o_SGMIIDuplex;
  logic [7:0]  o_SGMIISpeed;
  logic [63:0] o_LcAdvAbility;
  logic [83:0] o_LinkTimer;

  sgmii_reg_bank #(.NUM_CH(4), .ADDR_W(10), .LINK_TIMER_DEFAULT(21'h30D40)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Cyc(i_Cyc), .i_Stb(i_Stb), .i_WEn(i_WEn),
    .i_Addr(i_Addr), .i_WrData(i_WrData), .o_RdData(o_RdData), .o_Ack(o_Ack),
    .o_Stall(o_Stall), .i_XmitState(i_XmitState), .i_TxConfigReg(i_TxConfigReg),
    .i_LpAdvAbility(i_LpAdvAbility), .i_ANComplete(i_ANComplete),
    .i_SyncStatus(i_SyncStatus), .i_PhyLink(i_PhyLink), .i_PhyDuplex(i_PhyDuplex),
    .i_PhySpeed(i_PhySpeed), .o_MIIRst_L(o_MIIRst_L), .o_ANEnable(o_ANEnable),
    .o_ANRestart(o_ANRestart), .o_Loopback(o_Loopback), .o_GXBPowerDown(o_GXBPowerDown),
    .o_SGMIIDuplex(o_SGMIIDuplex), .o_SGMIISpeed(o_SGMIISpeed),
    .o_LcAdvAbility(o_LcAdvAbility), .o_LinkTimer(o_LinkTimer), .o_Irq(o_Irq)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    bit          isRd;
    logic [31:0] exp;
    int          cyc;
  } sbEnt_t;

  sbEnt_t sb[$];
  int     cyc = 0;
  int     nVec = 0, nMiss = 0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  // Monitor: every ack pops one expected transfer; checks latency and data
  always @(negedge i_Clk) begin
    if (o_Ack) begin
      nVec++;
      if (sb.size() == 0) begin
        nMiss++;
        $display("FAIL ack_unexpected at cycle %0d got ack=1 want ack=0", cyc);
      end else begin
        sbEnt_t e;
        e = sb.pop_front();
        if (cyc != e.cyc + 1) begin
          nMiss++;
          $display("FAIL ack_latency got cycle %0d want cycle %0d", cyc, e.cyc + 1);
        end else if (e.isRd && o_RdData !== e.exp) begin
          nMiss++;
          $display("FAIL read_data got %h want %h", o_RdData, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk); #1;
  endtask

  task automatic xfer(input bit we, input logic [9:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp);
    sbEnt_t e;
    i_Cyc = 1; i_Stb = 1; i_WEn = we; i_Addr = addr; i_WrData = wd;
    e.isRd = !we; e.exp = exp; e.cyc = cyc;
    sb.push_back(e);
    step();
    i_Cyc = 0; i_Stb = 0; i_WEn = 0;
  endtask

  function automatic logic [9:0] ad(input int ch, input int r);
    return 10'((ch << 7) | (r << 2));
  endfunction

  task automatic rd(input int ch, input int r, input logic [31:0] exp);
    xfer(1'b0, ad(ch, r), 32'h0, exp);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    xfer(1'b1, ad(ch, r), d, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got no finish want finish");
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss + 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    step(); step(); step();
    chk("rst_ack", {31'h0, o_Ack}, 32'h0);
    chk("rst_rddata", o_RdData, 32'h0);
    chk("rst_irq", {31'h0, o_Irq}, 32'h0);
    i_Rst = 0;
    step();
    chk("rst_miirst", {28'h0, o_MIIRst_L}, 32'hF);
    chk("rst_anen", {28'h0, o_ANEnable}, 32'hF);
    chk("rst_speed", {24'h0, o_SGMIISpeed}, 32'hAA);
    chk("rst_duplex", {28'h0, o_SGMIIDuplex}, 32'hF);
    chk("rst_timer0", {11'h0, o_LinkTimer[20:0]}, 32'h30D40);
    chk("rst_lcadv0", {16'h0, o_LcAdvAbility[15:0]}, 32'h01A0);
    chk("stall", {31'h0, o_Stall}, 32'h0);

    // Channel 0 defaults, back to back
    rd(0, 5'h00, 32'h1140);
    rd(0, 5'h0A, 32'h2000);
    rd(0, 5'h08, 32'h0D40);
    rd(0, 5'h09, 32'h0003);
    rd(0, 5'h01, 32'h0014);
    rd(0, 5'h01, 32'h001C);

    // Control self-clear and AN restart clear on CONFIG
    wr(2, 5'h00, 32'h9200);
    chk("miirst_pulse_low", {28'h0, o_MIIRst_L}, 32'hB);
    rd(2, 5'h00, 32'h1200);
    chk("miirst_back_high", {28'h0, o_MIIRst_L}, 32'hF);
    chk("anrestart_set", {31'h0, o_ANRestart[2]}, 32'h1);
    rd(2, 5'h00, 32'h1200);
    i_XmitState[8:6] = 3'd1;
    step();
    i_XmitState[8:6] = 3'd0;
    chk("anrestart_cleared", {31'h0, o_ANRestart[2]}, 32'h0);
    rd(2, 5'h00, 32'h1000);

    // Latched-low link and link-down interrupt on ch1
    wr(1, 5'h11, 32'h1);
    i_SyncStatus[1] = 0;
    step();
    i_SyncStatus[1] = 1;
    rd(1, 5'h01, 32'h0014);
    rd(1, 5'h01, 32'h001C);
    chk("irq_after_drop", {31'h0, o_Irq}, {31'h0, cIrq});
    rd(1, 5'h10, {31'h0, cIrq});

    // Write-1-to-clear coinciding with a new fall: event wins
    i_SyncStatus[1] = 0;
    wr(1, 5'h10, 32'h1);
    i_SyncStatus[1] = 1;
    rd(1, 5'h10, {31'h0, cIrq});
    chk("irq_held", {31'h0, o_Irq}, {31'h0, cIrq});
    wr(1, 5'h10, 32'h1);
    rd(1, 5'h10, 32'h0);
    chk("irq_dropped", {31'h0, o_Irq}, 32'h0);
    rd(1, 5'h11, {31'h0, cIrq});

    // Out-of-range channel 5 (aliases ch1 in the low channel bits)
    xfer(1'b1, 10'h2A0, 32'h1234, 32'h0);
    xfer(1'b0, 10'h2A0, 32'h0, 32'h0);
    chk("ch5_no_alias", {11'h0, o_LinkTimer[41:21]}, 32'h30D40);
    rd(1, 5'h08, 32'h0D40);

    // SGMII mode on ch3, link-partner-derived speed/duplex
    i_LpAdvAbility[63:48] = 16'h1800;
    wr(3, 5'h1F, 32'h1);
    chk("sgmii_lp_speed", {30'h0, o_SGMIISpeed[7:6]}, 32'h2);
    chk("sgmii_lp_duplex", {31'h0, o_SGMIIDuplex[3]}, 32'h1);
    rd(3, 5'h04, 32'h0001);
    rd(3, 5'h05, 32'h1800);

    // Local config selected
    i_PhySpeed[7:6] = 2'b01;
    wr(3, 5'h00, 32'h0);
    wr(3, 5'h1F, 32'h5);
    chk("local_speed", {30'h0, o_SGMIISpeed[7:6]}, 32'h1);
    chk("local_duplex", {31'h0, o_SGMIIDuplex[3]}, 32'h0);

    // PHY-side advertised word
    i_PhyLink[3] = 1;
    wr(3, 5'h1F, 32'h3);
    rd(3, 5'h04, 32'h8401);
    chk("phy_lcadv", {16'h0, o_LcAdvAbility[63:48]}, 32'h8401);
    rd(3, 5'h1F, 32'h0003);

    // Scratch and link-timer high write
    wr(0, 5'h0A, 32'hFFFF_BEEF);
    wr(0, 5'h09, 32'h1F);
    rd(0, 5'h0A, 32'hBEEF);
    chk("timer_hi_write", {11'h0, o_LinkTimer[20:0]}, 32'h1F0D40);

    // Reset during an in-flight request: no ack for it
    i_Rst = 1; i_Cyc = 1; i_Stb = 1; i_WEn = 0; i_Addr = ad(0, 5'h0A);
    step();
    i_Cyc = 0; i_Stb = 0;
    chk("rst_inflight_ack", {31'h0, o_Ack}, 32'h0);
    step();
    chk("rst_inflight_ack2", {31'h0, o_Ack}, 32'h0);
    i_Rst = 0;
    rd(0, 5'h0A, 32'h2000);

    step(); step(); step();
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/sgmii_reg_bank.md
# sgmii_reg_bank

Multi-channel management register bank for the SGMII / 1000BASE-X PCS, the parametrised successor of the single-channel register block. It serves `NUM_CH` PCS channels behind one pipelined Wishbone slave, and adds the following per channel:
- latched-low link status;
- a maskable interrupt-status register;
- a combined interrupt output.

It sits between the host bus bridge and the per-channel auto-negotiation, sync and transmit logic, all of which run on `i_Clk`.

## Interface
Parameters:
- `NUM_CH`, 4: number of PCS channels, 1..8.
- `ADDR_W`, 10: byte address width. It must be at least 7 + clog2(`NUM_CH`).
- `LINK_TIMER_DEFAULT`, 21'h30D40: link-timer reset value (1.6 ms at 125 MHz).

Ports:
- `i_Clk` in 1: clock. One clock for the whole block.
- `i_Rst` in 1: reset, synchronous and active-high.
- `i_Cyc`, `i_Stb`, `i_WEn` in 1 each: Wishbone cycle, strobe and write enable.
- `i_Addr` in `ADDR_W`: byte address.
- `i_WrData` in 32: write data. Only bits [15:0] are used.
- `o_RdData` out 32: read data.
- `o_Ack` out 1: transfer acknowledge.
- `o_Stall` out 1: tied 0.
- `i_XmitState` in 3·`NUM_CH`: per-channel transmit state.
- `i_TxConfigReg` in 16·`NUM_CH`: per-channel transmitted configuration word.
- `i_LpAdvAbility` in 16·`NUM_CH`: per-channel link-partner ability.
- `i_ANComplete`, `i_SyncStatus`, `i_PhyLink`, `i_PhyDuplex` in `NUM_CH` each.
- `i_PhySpeed` in 2·`NUM_CH`.
- `o_MIIRst_L`, `o_ANEnable`, `o_ANRestart`, `o_Loopback`, `o_GXBPowerDown`, `o_SGMIIDuplex` out `NUM_CH` each.
- `o_SGMIISpeed` out 2·`NUM_CH`.
- `o_LcAdvAbility` out 16·`NUM_CH`.
- `o_LinkTimer` out 21·`NUM_CH`.
- `o_Irq` out 1: OR of all channels' masked interrupt status.

## Operation
Address decode:
- Register index = `i_Addr[6:2]`.
- Channel = `i_Addr[7 +: clog2(NUM_CH)]`.
- Channel index ≥ `NUM_CH`: write ignored, read returns 0, transfer still acknowledged.

Per-channel registers (all bits are 0 unless stated):
- 0x00, control:
  - Fields: [15] reset, [14] loopback, [13]/[6] speed, [12] AN enable, [11] power-down, [9] AN restart, [8] duplex.
  - [15] self-clears one cycle after being written.
  - [9] clears on any cycle where the channel's `i_XmitState` equals CONFIG, unless a write to 0x00 occurs that cycle.
  - Reset value 0x1140.
- 0x01, status, read-only:
  - {9'h0, ANComplete, 2'b01, LinkLL, SyncStatus, 2'b0}, giving LinkLL at bit 3 and SyncStatus at bit 2.
  - LinkLL: cleared on any cycle where `i_SyncStatus`=0.
  - LinkLL: set to the current `i_SyncStatus` when 0x01 is read.
  - If the read and a sync drop coincide, LinkLL = 0.
  - LinkLL reset value 0.
- 0x04, advertised ability: the read value is `o_LcAdvAbility`. The mode-dependent formation is unchanged from the previous generation:
  - 1000-X mode: {0, TxCfg[15], Reg4[13:12], 000, Reg4[8:7], 01, 00000}.
  - SGMII PHY side: {PhyLink, TxCfg[15], 0, PhyDuplex|Reg4[12], PhySpeed|Reg4[11:10], 10'h1}.
  - SGMII MAC side: {0, TxCfg[15], 0, 000, 10'h1}.
  - The writable backing Reg4 resets to 0x01A0.
- 0x05, link-partner ability: read-only, returns `i_LpAdvAbility`.
- 0x08 / 0x09, link timer: bits [15:0] / [20:16].
- 0x0A, scratch: reset value 0x2000, which is the revision.
- 0x10, interrupt status, write-1-to-clear:
  - [0] link-down event: `i_SyncStatus` falling edge.
  - [1] `i_ANComplete` rising edge.
  - [2] `i_LpAdvAbility` changed since the previous cycle.
- 0x11, interrupt mask [2:0]: 1 = enabled. Reset value 0.
- 0x1F, mode:
  - [0] SGMII.
  - [1] PHY side.
  - [2] use local config.
  - Reset value 0.

Derived outputs (speed/duplex rules are unchanged from the previous generation):
- `o_SGMIISpeed`: 2'b10 when not in SGMII mode. Otherwise:
  - LP[11:10], or
  - {C0[6]|PhySpeed[1], C0[13]|PhySpeed[0]} when local config is selected.
- `o_SGMIIDuplex`: 1 when not in SGMII mode. Otherwise:
  - LP[12], or
  - C0[8]|PhyDuplex when local config is selected.
- `o_MIIRst_L` = ~C0[15].

## Timing
- Every cycle with `i_Cyc & i_Stb` is accepted, giving full throughput. `o_Stall` is 0.
- Request sampled at edge T:
  - `o_Ack` is high for exactly cycle T+1.
  - `o_RdData` is valid during cycle T+1 and holds its value until the next read.
  - A write takes effect on outputs from cycle T+1.
- Edge detection uses a 1-cycle registered copy of each input, so an event bit sets in the cycle after the input edge is visible.
- Write-1-to-clear coinciding with a new event on the same bit: the event wins and the bit stays 1.
- `o_Irq` is registered: high 1 cycle after a masked status bit sets.
- Reset values:
  - `o_Ack` = 0, `o_RdData` = 0, `o_Irq` = 0.
  - All registers return to their defaults.
  - Edge-detect history loads the current inputs, so no spurious events are raised on reset exit.
- A reset asserted while a request is in flight suppresses its ack; no ack is issued afterwards.

## Configuration
- `SGMII_REG_IRQ_EN` defined:
  - Registers 0x10/0x11, the edge detectors and `o_Irq` are present.
- Not defined:
  - 0x10/0x11 read 0 and writes to them are ignored.
  - `o_Irq` is tied 0.
  - No edge-detect flops are built.
  - LinkLL and all other behaviour are unchanged.

## Structure
- Package `sgmii_regs_pkg` holds:
  - register index constants;
  - reset-default constants;
  - the `cXmitCONFIG` encoding;
  - the control and interrupt bit positions.
- Sub-module `sgmii_reg_channel` holds one channel's registers, LinkLL, interrupt logic and derived outputs. It is instantiated `NUM_CH` times via generate.
- The top level holds:
  - bus accept and decode;
  - the registered read mux;
  - the ack flop;
  - the `o_Irq` OR.

## Test plan
- Reset, then read channel 0 registers 0x00 / 0x0A / 0x08 / 0x09:
  - returns 0x1140 / 0x2000 / 0x0D40 / 0x0003;
  - `o_Ack` is high exactly 1 cycle after each strobe.
- Back-to-back writes 0x00=0x9200 to ch2, then read ch2 0x00:
  - bit 15 reads 0 and `o_MIIRst_L`[2] pulses low for 1 cycle;
  - the value reads 0x1200 until `i_XmitState`[2] = CONFIG, then 0x1000.
- Drop `i_SyncStatus`[1] for 1 cycle, restore it, then read ch1 0x01 twice:
  - first read bit 3 = 0, second read bit 3 = 1;
  - with `SGMII_REG_IRQ_EN` and mask 0x1, `o_Irq` = 1 and 0x10 reads 0x1.
- Write 0x10=0x1 on ch1 in the same cycle as a new `i_SyncStatus` fall:
  - bit 0 remains 1;
  - a later clear with the input stable clears it and `o_Irq` drops.
- With `NUM_CH`=4, access channel 5 (`i_Addr` 0x2A0):
  - write ignored;
  - read returns 0x00000000;
  - ack still issued.
- Mode 0x1F=0x1 on ch3 with LP=0x1800:
  - `o_SGMIISpeed`[3] = 2'b10 and `o_SGMIIDuplex`[3] = 1.
- Mode 0x1F=0x5 with `i_PhySpeed`=01 and C0=0x0000:
  - `o_SGMIISpeed`[3] = 2'b01.
